wb_rr_arbiter: RTL and testbench

N-master Wishbone classic shared-bus arbiter. Generalises the core's two-port instruction/data bus mux to a parametrised number of masters. Each master keeps the bus for a full `cyc` period, and the arbiter selects the next owner either round-robin or by fixed priority. It sits between the per-port `wb_adapter` instances and the single system Wishbone slave port, with an optional bus-timeout watchdog.

---
 rtl/wb_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master Wishbone classic shared-bus arbiter, round-robin or fixed priority.
// Define WB_ARB_TIMEOUT_EN to build the bus-timeout watchdog that drives m_wb_err.
module wb_rr_arbiter #(
  parameter int unsigned num_masters    = 2,
  parameter int unsigned addr_width     = 32,
  parameter int unsigned data_width     = 32,
  parameter int unsigned strobe_width   = data_width / 8,
  parameter int unsigned fixed_priority = 0,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [num_masters*addr_width-1:0]   m_wb_adr,
  input  logic [num_masters*data_width-1:0]   m_wb_datwr,
  input  logic [num_masters-1:0]              m_wb_we,
  input  logic [num_masters-1:0]              m_wb_stb,
  input  logic [num_masters-1:0]              m_wb_cyc,
  input  logic [num_masters*strobe_width-1:0] m_wb_sel,
  output logic [data_width-1:0]               m_wb_datrd,
  output logic [num_masters-1:0]              m_wb_ack,
  output logic [num_masters-1:0]              m_wb_err,
  output logic [addr_width-1:0]               s_wb_adr,
  output logic [data_width-1:0]               s_wb_datwr,
  input  logic [data_width-1:0]               s_wb_datrd,
  output logic                                s_wb_we,
  output logic                                s_wb_stb,
  output logic                                s_wb_cyc,
  output logic [strobe_width-1:0]             s_wb_sel,
  input  logic                                s_wb_ack,
  output logic [num_masters-1:0]              grant
);

  localparam int unsigned NM    = num_masters;
  localparam int unsigned IDX_W = $clog2(num_masters);

  if (num_masters < 2 || timeout_cycles < 1 || timeout_cycles > 65535) begin : g_cfg_check
    $error("wb_rr_arbiter: need num_masters >= 2 and timeout_cycles in 1..65535");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NM-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0] win_idx_c;
  logic             win_found_c;
  logic             own_cyc_c;
  logic             own_stb_c;
  logic             timeout_c;

  // Winner search: from last+1 wrapping (round-robin) or from index 0 (fixed priority).
  always_comb begin
    int unsigned idx;
    idx         = 0;
    win_idx_c   = '0;
    win_found_c = 1'b0;
    for (int unsigned k = 0; k < NM; k++) begin
      idx = (fixed_priority != 0) ? k : (32'(last_q) + 32'd1 + k) % NM;
      if (!win_found_c && m_wb_cyc[IDX_W'(idx)]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'(idx);
      end
    end
  end

  assign own_cyc_c = m_wb_cyc[gidx_q];
  assign own_stb_c = m_wb_stb[gidx_q];

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;

  // Watchdog counts strobed cycles without an ack since grant or the last ack.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == IDLE || s_wb_ack) begin
      tcnt_d = '0;
    end else if (s_wb_stb) begin
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign timeout_c = (state_q == BUSY) && (tcnt_q == 16'(timeout_cycles));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NM - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (win_found_c) begin
          state_d = BUSY;
          gidx_d  = win_idx_c;
          grant_d = NM'(1) << win_idx_c;
        end
      end
      BUSY: begin
        if (!own_cyc_c || timeout_c) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner's slice reaches the slave only while BUSY; a timeout cuts cyc/stb on its cycle.
  always_comb begin
    s_wb_adr   = '0;
    s_wb_datwr = '0;
    s_wb_we    = 1'b0;
    s_wb_stb   = 1'b0;
    s_wb_cyc   = 1'b0;
    s_wb_sel   = '0;
    m_wb_ack   = '0;
    m_wb_err   = '0;
    if (state_q == BUSY) begin
      s_wb_adr         = m_wb_adr[32'(gidx_q) * addr_width +: addr_width];
      s_wb_datwr       = m_wb_datwr[32'(gidx_q) * data_width +: data_width];
      s_wb_sel         = m_wb_sel[32'(gidx_q) * strobe_width +: strobe_width];
      s_wb_we          = m_wb_we[gidx_q];
      s_wb_cyc         = own_cyc_c & ~timeout_c;
      s_wb_stb         = own_stb_c & ~timeout_c;
      m_wb_ack[gidx_q] = s_wb_ack;
      m_wb_err[gidx_q] = timeout_c;
    end
  end

  assign grant      = grant_q;
  assign m_wb_datrd = s_wb_datrd;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: instance 0 round-robin, instance 1 fixed priority, 3 masters each.
// A behavioural bus-ownership model is compared against both instances on every cycle.
module tb_wb_rr_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [NM*AW-1:0] m_adr   [2];
  logic [NM*DW-1:0] m_dat   [2];
  logic [NM-1:0]    m_we    [2];
  logic [NM-1:0]    m_stb   [2];
  logic [NM-1:0]    m_cyc   [2];
  logic [NM*SW-1:0] m_sel   [2];
  logic [DW-1:0]    s_datrd [2];
  logic             s_ack   [2];

  logic [DW-1:0]    m_datrd [2];
  logic [NM-1:0]    m_ack   [2];
  logic [NM-1:0]    m_err   [2];
  logic [NM-1:0]    grant   [2];
  logic [AW-1:0]    s_adr   [2];
  logic [DW-1:0]    s_dat   [2];
  logic             s_we    [2];
  logic             s_stb   [2];
  logic             s_cyc   [2];
  logic [SW-1:0]    s_sel   [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who owns the bus, who owned it last, stalled-strobe count.
  bit busy  [2];
  int owner [2];
  int last  [2];
  int cnt   [2];

  int rr_exp [6] = '{0, 1, 2, 0, 1, 2};

  always #5 clock = ~clock;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    wb_rr_arbiter #(
      .num_masters(NM), .addr_width(AW), .data_width(DW), .strobe_width(SW),
      .fixed_priority(d), .timeout_cycles(TO)
    ) u_dut (
      .clock(clock), .reset(reset),
      .m_wb_adr(m_adr[d]), .m_wb_datwr(m_dat[d]), .m_wb_we(m_we[d]),
      .m_wb_stb(m_stb[d]), .m_wb_cyc(m_cyc[d]), .m_wb_sel(m_sel[d]),
      .m_wb_datrd(m_datrd[d]), .m_wb_ack(m_ack[d]), .m_wb_err(m_err[d]),
      .s_wb_adr(s_adr[d]), .s_wb_datwr(s_dat[d]), .s_wb_datrd(s_datrd[d]),
      .s_wb_we(s_we[d]), .s_wb_stb(s_stb[d]), .s_wb_cyc(s_cyc[d]),
      .s_wb_sel(s_sel[d]), .s_wb_ack(s_ack[d]), .grant(grant[d])
    );
  end

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int pick(input bit fp, input int lst, input logic [NM-1:0] req);
    int i;
    for (int k = 1; k <= NM; k++) begin
      i = fp ? k - 1 : (lst + k) % NM;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_check(input int d);
    bit            tout;
    logic [NM-1:0] e_grant, e_ack, e_err;
    tout    = TO_EN && busy[d] && (cnt[d] == TO);
    e_grant = '0;
    e_ack   = '0;
    e_err   = '0;
    if (busy[d]) begin
      e_grant[owner[d]] = 1'b1;
      e_ack[owner[d]]   = s_ack[d];
      e_err[owner[d]]   = tout;
      chk("m_s_adr", d, s_adr[d], m_adr[d][owner[d]*AW +: AW]);
      chk("m_s_dat", d, s_dat[d], m_dat[d][owner[d]*DW +: DW]);
      chk("m_s_sel", d, s_sel[d], m_sel[d][owner[d]*SW +: SW]);
      chk("m_s_we",  d, s_we[d],  m_we[d][owner[d]]);
      chk("m_s_cyc", d, s_cyc[d], m_cyc[d][owner[d]] && !tout);
      chk("m_s_stb", d, s_stb[d], m_stb[d][owner[d]] && !tout);
    end else begin
      chk("m_idle_bus", d, {s_adr[d], s_dat[d]}, 64'd0);
      chk("m_idle_ctl", d, {s_sel[d], s_we[d], s_cyc[d], s_stb[d]}, 64'd0);
    end
    chk("m_grant", d, grant[d], e_grant);
    chk("m_ack",   d, m_ack[d], e_ack);
    chk("m_err",   d, m_err[d], e_err);
    chk("m_datrd", d, m_datrd[d], s_datrd[d]);
  endtask

  task automatic model_step(input int d);
    bit tout;
    if (!busy[d]) begin
      if (m_cyc[d] != '0) begin
        busy[d]  = 1'b1;
        owner[d] = pick(d == 1, last[d], m_cyc[d]);
        cnt[d]   = 0;
      end
    end else begin
      tout = TO_EN && (cnt[d] == TO);
      if (!m_cyc[d][owner[d]] || tout) begin
        busy[d] = 1'b0;
        last[d] = owner[d];
      end else if (s_ack[d]) begin
        cnt[d] = 0;
      end else if (m_stb[d][owner[d]]) begin
        cnt[d] = cnt[d] + 1;
      end
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        busy[d]  = 1'b0;
        owner[d] = 0;
        last[d]  = NM - 1;
        cnt[d]   = 0;
      end
      model_check(d);
      if (!reset) model_step(d);
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '0; m_dat[d] = '0; m_we[d] = '0; m_stb[d] = '0; m_cyc[d] = '0;
      m_sel[d] = '0; s_datrd[d] = '0; s_ack[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // One ownership round from an IDLE cycle: grant w, one ack, w drops cyc, bus idles.
  task automatic round(input int d, input int w, input logic [NM-1:0] req, input string tag);
    m_cyc[d] = req;
    m_stb[d] = req;
    smp(); chk({tag, "_idle"}, d, grant[d], 64'd0);
    nxt(); smp(); chk({tag, "_grant"}, d, grant[d], NM'(1) << w);
    nxt(); s_ack[d] = 1'b1;
    smp(); chk({tag, "_ack"}, d, m_ack[d], NM'(1) << w);
    nxt(); s_ack[d] = 1'b0; m_cyc[d][w] = 1'b0; m_stb[d][w] = 1'b0;
    smp(); chk({tag, "_hold"}, d, grant[d], NM'(1) << w);
    nxt();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    nxt(); nxt();
    reset = 1'b0;

    // Reset state
    smp();
    chk("rst_grant", 0, grant[0], 64'd0);
    chk("rst_s_cyc", 0, s_cyc[0], 64'd0);
    chk("rst_m_ack", 0, m_ack[0], 64'd0);
    chk("rst_m_err", 0, m_err[0], 64'd0);

    // Single request from master 1
    nxt();
    m_cyc[0] = 3'b010; m_stb[0] = 3'b010; m_adr[0][AW +: AW] = 32'h100;
    smp(); chk("t1_idle", 0, grant[0], 64'd0);
    nxt(); smp();
    chk("t1_grant", 0, grant[0], 64'b010);
    chk("t1_adr",   0, s_adr[0], 64'h100);
    chk("t1_cyc",   0, s_cyc[0], 64'd1);
    nxt(); s_ack[0] = 1'b1;
    smp(); chk("t1_ack", 0, m_ack[0], 64'b010);
    nxt(); s_ack[0] = 1'b0; m_cyc[0] = '0; m_stb[0] = '0;
    smp(); chk("t1_release_cyc", 0, grant[0], 64'b010);
    nxt(); smp(); chk("t1_idle_after", 0, grant[0], 64'd0);

    // Round-robin fairness
    nxt(); do_reset();
    for (int k = 0; k < 6; k++) round(0, rr_exp[k], 3'b111, "rr");

    // Fixed priority: master 0 keeps winning; master 2 only once 0 and 1 are gone
    do_reset();
    round(1, 0, 3'b111, "fp_a");
    round(1, 0, 3'b111, "fp_b");
    round(1, 1, 3'b110, "fp_c");
    round(1, 2, 3'b100, "fp_d");

    // Block cycle: master 0 does 4 beats while master 1 waits
    do_reset();
    m_cyc[0] = 3'b011; m_stb[0] = 3'b011;
    smp(); chk("blk_idle", 0, grant[0], 64'd0);
    nxt(); smp(); chk("blk_grant0", 0, grant[0], 64'b001);
    for (int b = 0; b < 4; b++) begin
      nxt(); s_ack[0] = 1'b1;
      smp(); chk("blk_ack0", 0, m_ack[0], 64'b001);
      nxt(); s_ack[0] = 1'b0;
      smp(); chk("blk_hold0", 0, grant[0], 64'b001);
    end
    nxt(); m_cyc[0][0] = 1'b0; m_stb[0][0] = 1'b0;
    smp(); chk("blk_release", 0, grant[0], 64'b001);
    nxt(); smp(); chk("blk_gap", 0, grant[0], 64'd0);
    nxt(); smp(); chk("blk_grant1", 0, grant[0], 64'b010);

    // Reset while BUSY with stb high
    nxt(); do_reset();
    m_cyc[0] = 3'b001; m_stb[0] = 3'b001;
    smp(); nxt(); smp();
    chk("mrst_grant_pre", 0, grant[0], 64'b001);
    chk("mrst_stb_pre",   0, s_stb[0], 64'd1);
    nxt(); s_ack[0] = 1'b1; reset = 1'b1;
    #1;
    chk("mrst_cyc",   0, s_cyc[0], 64'd0);
    chk("mrst_stb",   0, s_stb[0], 64'd0);
    chk("mrst_grant", 0, grant[0], 64'd0);
    chk("mrst_ack",   0, m_ack[0], 64'd0);
    nxt(); reset = 1'b0; s_ack[0] = 1'b0; m_cyc[0] = 3'b111; m_stb[0] = 3'b111;
    smp(); chk("mrst_idle", 0, grant[0], 64'd0);
    nxt(); smp(); chk("mrst_first_rr", 0, grant[0], 64'b001);
    nxt(); m_cyc[0] = '0; m_stb[0] = '0;

    // Watchdog: slave never acks
    do_reset();
    m_cyc[0] = 3'b001; m_stb[0] = 3'b001;
    smp(); nxt();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin m_cyc[0] = '0; m_stb[0] = '0; end
      smp();
      chk("to_err", 0, m_err[0], (i == 8) ? 64'd1 : 64'd0);
      if (i == 8) chk("to_cyc_cut", 0, s_cyc[0], 64'd0);
      if (i == 9) chk("to_release", 0, grant[0], 64'd0);
      nxt();
    end
`else
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("noto_err",   0, m_err[0], 64'd0);
      chk("noto_grant", 0, grant[0], 64'b001);
      nxt();
    end
    m_cyc[0] = '0; m_stb[0] = '0;
`endif

    // Randomised traffic on both instances
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NM; i++)
          if ($urandom_range(0, 5) == 0) m_cyc[d][i] = ~m_cyc[d][i];
        m_stb[d]   = NM'($urandom);
        m_we[d]    = NM'($urandom);
        m_adr[d]   = {$urandom, $urandom, $urandom};
        m_dat[d]   = {$urandom, $urandom, $urandom};
        m_sel[d]   = (NM*SW)'($urandom);
        s_datrd[d] = $urandom;
        s_ack[d]   = ($urandom_range(0, 6) == 0);
      end
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
